// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port RAM between a CPU and a DMA requester, round-robin with an optional bounded DMA burst lock.
// Latency: a request eligible in slot N is acked (with read data) in cycle N+1; a write lands at the edge ending slot N.
// Backpressure: a requester holds req/cmd until its ack and is never served in its own ack cycle.
module mem_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    input  logic          dma_lock,
    output logic          mem_write_enable,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_write_data,
    input  logic [DW-1:0] mem_read_data,
    output logic [1:0]    last_owner
);
    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
    localparam logic [1:0]    OWN_NONE  = 2'b00;
    localparam logic [1:0]    OWN_CPU   = 2'b01;
    localparam logic [1:0]    OWN_DMA   = 2'b10;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e   state_q, state_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          rr_last_q, rr_last_d;        // 1: DMA was granted last
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic [1:0]    last_owner_q, last_owner_d;

    logic cpu_elig;
    logic dma_elig;
    logic burst_spent;
    logic lock_active;
    logic grant_cpu;
    logic grant_dma;

    // A requester sitting in its ack cycle is not eligible, so back-to-back
    // accesses from one side are at least two cycles apart.
    assign cpu_elig    = cpu_req & ~cpu_ack_q;
    assign dma_elig    = dma_req & ~dma_ack_q;
    // Once the burst budget is used up and the CPU is waiting, the lock lets go.
    assign burst_spent = (burst_cnt_q == BURST_MAX) & cpu_elig;
    assign lock_active = (state_q == LOCKED) & dma_lock & ~burst_spent;

    // Pick the slot winner; nothing wins while reset is asserted.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (rst_n) begin
            if (lock_active) begin
                // CPU is shut out, even during the DMA ack gap (slot idles).
                grant_dma = dma_elig;
            end else if (cpu_elig && dma_elig) begin
                grant_cpu = rr_last_q;
                grant_dma = ~rr_last_q;
            end else begin
                grant_cpu = cpu_elig;
                grant_dma = dma_elig;
            end
        end
    end

    // Drive the memory port from the winner; all zero on an idle slot.
    always_comb begin
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        if (grant_cpu) begin
            mem_write_enable = cpu_we & rst_n;
            mem_address      = cpu_addr;
            mem_write_data   = cpu_wdata;
        end else if (grant_dma) begin
            mem_write_enable = dma_we & rst_n;
            mem_address      = dma_addr;
            mem_write_data   = dma_wdata;
        end
    end

    // Lock FSM next state: enter on a locked DMA win, count DMA wins, release
    // on lock drop, DMA request withdrawal, or the forced CPU grant.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            UNLOCKED: begin
                burst_cnt_d = '0;
                if (grant_dma && dma_lock) begin
                    state_d     = LOCKED;
                    burst_cnt_d = CW'(1);
                end
            end
            LOCKED: begin
                if (!dma_lock || (!dma_req && !dma_ack_q) || grant_cpu) begin
                    state_d     = UNLOCKED;
                    burst_cnt_d = '0;
                end else if (grant_dma && (burst_cnt_q != BURST_MAX)) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d     = UNLOCKED;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Slot completion: one-cycle ack, read capture, fairness pointer, owner code.
    always_comb begin
        cpu_ack_d    = grant_cpu;
        dma_ack_d    = grant_dma;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        rr_last_d    = rr_last_q;
        last_owner_d = OWN_NONE;
        if (grant_cpu) begin
            rr_last_d    = 1'b0;
            last_owner_d = OWN_CPU;
            if (!cpu_we) begin
                cpu_rdata_d = mem_read_data;
            end
        end else if (grant_dma) begin
            rr_last_d    = 1'b1;
            last_owner_d = OWN_DMA;
            if (!dma_we) begin
                dma_rdata_d = mem_read_data;
            end
        end
    end

    // Completion registers; reset leaves DMA as last granted so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            rr_last_q    <= 1'b1;
            last_owner_q <= OWN_NONE;
        end else begin
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            rr_last_q    <= rr_last_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign dma_ack    = dma_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign last_owner = last_owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table of per-cycle vectors plus randomized
// protocol-legal traffic compared against a slot-level reference model.
// A bench-side 4096x16 RAM with combinational read serves the arbiter.
module tb_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [AW-1:0] cpu_addr, dma_addr, mem_address;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_write_data, mem_read_data;
    logic          cpu_ack, dma_ack, mem_write_enable;
    logic [1:0]    last_owner;

    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_dat;
    logic [DW-1:0] mem [0:4095];

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_lock(dma_lock),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .last_owner(last_owner)
    );

    // RAM: arbiter writes take priority; the preload port is used only on idle slots.
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_write_data;
        else if (pl_we)       mem[pl_addr] <= pl_dat;
    end
    assign mem_read_data = mem[mem_address];

    typedef struct {
        logic rst_n;
        logic creq; logic cwe; logic [AW-1:0] caddr; logic [DW-1:0] cwd;
        logic dreq; logic dwe; logic [AW-1:0] daddr; logic [DW-1:0] dwd;
        logic lock;
        logic pl_we; logic [AW-1:0] pl_addr; logic [DW-1:0] pl_dat;
    } stim_t;

    typedef struct {
        logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
        logic cack; logic dack; logic [DW-1:0] crd; logic [DW-1:0] drd;
        logic [1:0] lo;
    } exp_t;

    typedef struct { stim_t s; exp_t e; } vec_t;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state (slot-level view of the arbiter's observable behaviour)
    logic          m_cack, m_dack;
    logic [DW-1:0] m_crd, m_drd;
    logic [1:0]    m_lo;
    bit            m_rr_dma;   // DMA was the most recent grant
    bit            m_locked;
    int            m_cnt;
    logic [DW-1:0] m_mem [0:4095];

    // Random requester state
    logic          g_creq = 1'b0, g_cwe = 1'b0, g_dreq = 1'b0, g_dwe = 1'b0, g_lock = 1'b0;
    logic [AW-1:0] g_caddr = '0, g_daddr = '0;
    logic [DW-1:0] g_cwd = '0, g_dwd = '0;

    function automatic stim_t st(logic r, logic cq, logic cw, logic [AW-1:0] ca, logic [DW-1:0] cd,
                                 logic dq, logic dw, logic [AW-1:0] da, logic [DW-1:0] dd, logic lk);
        stim_t s;
        s.rst_n = r;
        s.creq = cq; s.cwe = cw; s.caddr = ca; s.cwd = cd;
        s.dreq = dq; s.dwe = dw; s.daddr = da; s.dwd = dd;
        s.lock = lk;
        s.pl_we = 1'b0; s.pl_addr = '0; s.pl_dat = '0;
        return s;
    endfunction

    function automatic exp_t ex(logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic ca, logic da,
                                logic [DW-1:0] cr, logic [DW-1:0] dr, logic [1:0] lo);
        exp_t e;
        e.we = w; e.addr = a; e.wdata = d; e.cack = ca; e.dack = da; e.crd = cr; e.drd = dr; e.lo = lo;
        return e;
    endfunction

    function automatic vec_t v(stim_t s, exp_t e);
        vec_t r;
        r.s = s; r.e = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp_all(input string tag, input exp_t x);
        check({tag, ".mem_we"},     32'(mem_write_enable), 32'(x.we));
        check({tag, ".mem_addr"},   32'(mem_address),      32'(x.addr));
        check({tag, ".mem_wdata"},  32'(mem_write_data),   32'(x.wdata));
        check({tag, ".cpu_ack"},    32'(cpu_ack),          32'(x.cack));
        check({tag, ".dma_ack"},    32'(dma_ack),          32'(x.dack));
        check({tag, ".cpu_rdata"},  32'(cpu_rdata),        32'(x.crd));
        check({tag, ".dma_rdata"},  32'(dma_rdata),        32'(x.drd));
        check({tag, ".last_owner"}, 32'(last_owner),       32'(x.lo));
    endtask

    // One memory slot: drive at posedge+1, compare mid-cycle, then advance the model.
    task automatic step(input stim_t s, input bit use_tbl, input exp_t e, input string tag);
        exp_t me;
        bit   ce, de, hold;
        int   win;
        @(posedge clk);
        #1;
        rst_n = s.rst_n;
        cpu_req = s.creq; cpu_we = s.cwe; cpu_addr = s.caddr; cpu_wdata = s.cwd;
        dma_req = s.dreq; dma_we = s.dwe; dma_addr = s.daddr; dma_wdata = s.dwd;
        dma_lock = s.lock;
        pl_we = s.pl_we; pl_addr = s.pl_addr; pl_dat = s.pl_dat;
        #3;
        ce   = s.creq && !m_cack;
        de   = s.dreq && !m_dack;
        // DMA keeps the memory while locked unless its budget is spent with the CPU waiting
        hold = m_locked && s.lock && !(m_cnt == MB && ce);
        win  = 0;
        if (s.rst_n) begin
            if (ce && !hold && (!de || m_rr_dma)) win = 1;
            else if (de)                          win = 2;
        end
        me = ex(L, '0, '0, m_cack, m_dack, m_crd, m_drd, m_lo);
        if (win == 1) begin me.we = s.cwe; me.addr = s.caddr; me.wdata = s.cwd; end
        if (win == 2) begin me.we = s.dwe; me.addr = s.daddr; me.wdata = s.dwd; end
        cmp_all({tag, ".model"}, me);
        if (use_tbl) cmp_all({tag, ".table"}, e);

        if (!s.rst_n) begin
            m_cack = 1'b0; m_dack = 1'b0; m_crd = '0; m_drd = '0; m_lo = 2'b00;
            m_rr_dma = 1'b1; m_locked = 1'b0; m_cnt = 0;
        end else begin
            if (win == 1) begin
                if (s.cwe) m_mem[s.caddr] = s.cwd; else m_crd = m_mem[s.caddr];
            end else if (win == 2) begin
                if (s.dwe) m_mem[s.daddr] = s.dwd; else m_drd = m_mem[s.daddr];
            end else if (s.pl_we) begin
                m_mem[s.pl_addr] = s.pl_dat;
            end
            if (!s.lock || (!s.dreq && !m_dack) || win == 1) begin
                m_locked = 1'b0; m_cnt = 0;
            end else if (win == 2) begin
                if (m_locked) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                else begin m_locked = 1'b1; m_cnt = 1; end
            end
            m_cack = (win == 1);
            m_dack = (win == 2);
            m_lo   = 2'(win);
            if (win != 0) m_rr_dma = (win == 2);
        end
    endtask

    // Protocol-legal random requesters: command may change only when idle or in the ack cycle.
    task automatic gen(output stim_t s);
        if (!g_creq || m_cack) begin
            g_creq  = ($urandom_range(0, 2) != 0);
            g_cwe   = 1'($urandom_range(0, 1));
            g_caddr = 12'($urandom_range(0, 15));
            g_cwd   = 16'($urandom);
        end
        if (!g_dreq || m_dack) begin
            g_dreq  = ($urandom_range(0, 2) != 0);
            g_dwe   = 1'($urandom_range(0, 1));
            g_daddr = 12'($urandom_range(0, 15));
            g_dwd   = 16'($urandom);
        end
        if ($urandom_range(0, 9) == 0) g_lock = ~g_lock;
        s = st(($urandom_range(0, 199) != 0), g_creq, g_cwe, g_caddr, g_cwd,
               g_dreq, g_dwe, g_daddr, g_dwd, g_lock);
    endtask

    initial begin : main
        vec_t  tbl[$];
        stim_t idle, rst, both, both_lk, s;
        exp_t  none;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_lock = 1'b0;
        pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
        m_cack = 1'b0; m_dack = 1'b0; m_crd = '0; m_drd = '0; m_lo = 2'b00;
        m_rr_dma = 1'b1; m_locked = 1'b0; m_cnt = 0;

        idle    = st(H, L, L, 12'h0, 16'h0, L, L, 12'h0, 16'h0, L);
        rst     = st(L, L, L, 12'h0, 16'h0, L, L, 12'h0, 16'h0, L);
        both    = st(H, H, L, 12'h740, 16'h0, H, L, 12'h123, 16'h0, L);
        both_lk = st(H, H, L, 12'h740, 16'h0, H, L, 12'h123, 16'h0, H);
        none    = ex(L, 12'h0, 16'h0, L, L, 16'h0, 16'h0, 2'b00);

        // Reset: all outputs zero
        step(rst, 1'b0, none, "rst0");
        step(rst, 1'b1, none, "rst1");

        // Preload RAM through idle slots
        for (int a = 0; a < 19; a++) begin
            s = idle;
            s.pl_we = 1'b1;
            s.pl_addr = (a < 16) ? 12'(a) : (a == 16) ? 12'h740 : (a == 17) ? 12'h500 : 12'h123;
            s.pl_dat  = (a < 16) ? 16'($urandom) : (a == 16) ? 16'h0030 : (a == 17) ? 16'h1111 : 16'h5555;
            step(s, 1'b0, none, "preload");
        end

        // Single CPU read of 0x740
        tbl.push_back(v(st(H, H, L, 12'h740, 16'h0, L, L, 12'h0, 16'h0, L), ex(L, 12'h740, 16'h0, L, L, 16'h0, 16'h0, 2'b00)));
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, H, L, 16'h0030, 16'h0, 2'b01)));
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, L, L, 16'h0030, 16'h0, 2'b00)));
        // DMA write 0x123 <- BEEF, then CPU read of 0x123 the next cycle
        tbl.push_back(v(st(H, L, L, 12'h0, 16'h0, H, H, 12'h123, 16'hBEEF, L), ex(H, 12'h123, 16'hBEEF, L, L, 16'h0030, 16'h0, 2'b00)));
        tbl.push_back(v(st(H, H, L, 12'h123, 16'h0, L, L, 12'h0, 16'h0, L), ex(L, 12'h123, 16'h0, L, H, 16'h0030, 16'h0, 2'b10)));
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, H, L, 16'hBEEF, 16'h0, 2'b01)));
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, L, L, 16'hBEEF, 16'h0, 2'b00)));
        // Reset, then both requesting continuously: CPU, DMA alternate
        tbl.push_back(v(rst, ex(L, 12'h0, 16'h0, L, L, 16'hBEEF, 16'h0, 2'b00)));
        tbl.push_back(v(both, ex(L, 12'h740, 16'h0, L, L, 16'h0, 16'h0, 2'b00)));
        tbl.push_back(v(both, ex(L, 12'h123, 16'h0, H, L, 16'h0030, 16'h0, 2'b01)));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(v(both, ex(L, 12'h740, 16'h0, L, H, 16'h0030, 16'hBEEF, 2'b10)));
            tbl.push_back(v(both, ex(L, 12'h123, 16'h0, H, L, 16'h0030, 16'hBEEF, 2'b01)));
        end
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, L, H, 16'h0030, 16'hBEEF, 2'b10)));
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, L, L, 16'h0030, 16'hBEEF, 2'b00)));
        // Lock burst: CPU, then 4 DMA grants with idle gaps, forced CPU, then round-robin without lock
        tbl.push_back(v(both_lk, ex(L, 12'h740, 16'h0, L, L, 16'h0030, 16'hBEEF, 2'b00)));
        tbl.push_back(v(both_lk, ex(L, 12'h123, 16'h0, H, L, 16'h0030, 16'hBEEF, 2'b01)));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(v(both_lk, ex(L, 12'h0, 16'h0, L, H, 16'h0030, 16'hBEEF, 2'b10)));
            tbl.push_back(v(both_lk, ex(L, 12'h123, 16'h0, L, L, 16'h0030, 16'hBEEF, 2'b00)));
        end
        tbl.push_back(v(both_lk, ex(L, 12'h740, 16'h0, L, H, 16'h0030, 16'hBEEF, 2'b10)));
        tbl.push_back(v(both, ex(L, 12'h123, 16'h0, H, L, 16'h0030, 16'hBEEF, 2'b01)));
        tbl.push_back(v(both, ex(L, 12'h740, 16'h0, L, H, 16'h0030, 16'hBEEF, 2'b10)));
        tbl.push_back(v(both, ex(L, 12'h123, 16'h0, H, L, 16'h0030, 16'hBEEF, 2'b01)));
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, L, H, 16'h0030, 16'hBEEF, 2'b10)));
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, L, L, 16'h0030, 16'hBEEF, 2'b00)));
        // Reset during a CPU write of 0x500: write suppressed, outputs cleared, old data read back
        tbl.push_back(v(st(L, H, H, 12'h500, 16'h2222, L, L, 12'h0, 16'h0, L), ex(L, 12'h0, 16'h0, L, L, 16'h0030, 16'hBEEF, 2'b00)));
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, L, L, 16'h0, 16'h0, 2'b00)));
        tbl.push_back(v(st(H, H, L, 12'h500, 16'h0, L, L, 12'h0, 16'h0, L), ex(L, 12'h500, 16'h0, L, L, 16'h0, 16'h0, 2'b00)));
        tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, H, L, 16'h1111, 16'h0, 2'b01)));
        // Ten idle slots
        for (int k = 0; k < 10; k++) tbl.push_back(v(idle, ex(L, 12'h0, 16'h0, L, L, 16'h1111, 16'h0, 2'b00)));

        foreach (tbl[i]) step(tbl[i].s, 1'b1, tbl[i].e, $sformatf("tbl%0d", i));

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            gen(s);
            step(s, 1'b0, none, $sformatf("rnd%0d", i));
        end
        step(idle, 1'b0, none, "drain");
        @(posedge clk);
        #1;

        for (int a = 0; a < 16; a++) check($sformatf("ram[%0d]", a), 32'(mem[a]), 32'(m_mem[a]));
        check("ram[0x500]", 32'(mem[12'h500]), 32'h1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 4096x16 main memory between the CPU fetch/execute path and a DMA/loader requester. Each clock cycle is one memory slot. The arbiter picks at most one winner per slot and drives the memory address, write-enable and write-data. On the slot's clock edge it captures the combinational read data for the winner and returns a one-cycle acknowledge. Fairness is round-robin, with an optional bounded DMA lock for bursts.

## Interface
Parameters:
- AW, 12, memory address width
- DW, 16, data width
- MAX_BURST, 8, max consecutive DMA grants under dma_lock while the CPU is waiting (≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU request; held with cmd stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid while cpu_ack=1, held until next CPU access
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same as CPU set, for DMA
- dma_lock  in  1  DMA requests burst ownership
- mem_write_enable  out  1  to memory write_enable
- mem_address  out  AW  to memory address
- mem_write_data  out  DW  to memory write_data
- mem_read_data  in  DW  from memory read_data (combinational read)
- last_owner  out  2  registered: 00 none, 01 CPU, 10 DMA winner of previous slot

## Operation
- Eligibility: cpu_elig = cpu_req & ~cpu_ack; dma_elig = dma_req & ~dma_ack.
  - A request is never served in its own ack cycle, so each requester gets at most one access every 2 cycles.
- Winner per slot, combinational from eligibility and registered state:
  - Only one eligible: that one wins, subject to the lock rule.
  - Both eligible, no lock: round-robin. The requester not granted last wins. rr_last holds the last granted requester (CPU or DMA).
  - Lock rule: when lock_active=1, the CPU cannot win. This holds even in DMA ack gap cycles; those slots stay idle.
- Lock state machine, states UNLOCKED and LOCKED; burst_cnt counts 0..MAX_BURST:
  - UNLOCKED→LOCKED: DMA wins with dma_lock=1. burst_cnt := 1.
  - In LOCKED, each DMA win increments burst_cnt.
  - lock_active = LOCKED & dma_lock & ~(burst_cnt==MAX_BURST & cpu_elig).
  - At burst_cnt==MAX_BURST with the CPU eligible, the CPU is forced to win the next slot. After that CPU grant, return to UNLOCKED and set burst_cnt := 0.
  - dma_lock=0, or dma_req=0 in a non-ack cycle → UNLOCKED, burst_cnt := 0.
- Memory drive when there is a winner:
  - mem_address = winner addr.
  - mem_write_data = winner wdata.
  - mem_write_enable = winner we & rst_n.
- Memory drive with no winner: all mem_* = 0.
- At the slot edge:
  - winner_ack := 1 for exactly one cycle.
  - If the access is a read, winner_rdata := mem_read_data. On a write, rdata is unchanged.
  - rr_last := winner.
  - last_owner := winner code, or 00 if the slot was idle.

## Timing
- Reset values: cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=0, last_owner=00, rr_last=DMA (CPU wins the first tie), state UNLOCKED, burst_cnt=0.
- mem_* outputs are 0 during reset cycles.
- Latency: request eligible in cycle N → ack and rdata valid in cycle N+1. The write lands in memory at the edge ending cycle N.
- Read-after-write by the other requester in cycle N+1 returns the new data.
- Requester may drop req in its ack cycle, or keep it high with a new command. The new command is served no earlier than N+2.
- Both eligible every cycle, no lock: grants alternate CPU, DMA, CPU, … Memory is used every cycle.
- Reset mid-access: rst_n=0 at an edge suppresses that slot's write (write_enable gated) and clears all state. No ack is issued.
- Changing req, we, addr or wdata before ack is illegal. Behaviour in that case is unspecified, but no X may propagate to mem_write_enable.

## Test plan
- Single CPU read: M[0x740]=0x0030, cpu_req/addr=0x740 cycle 0 → mem_address=0x740 cycle 0; cpu_ack=1, cpu_rdata=0x0030 cycle 1; last_owner=01.
- DMA write then CPU read: dma write 0x123←0xBEEF in cycle 0, CPU read 0x123 in cycle 1 → cpu_rdata=0xBEEF in cycle 2.
- Simultaneous continuous requests from reset, no lock → grant order CPU, DMA, CPU, DMA over 8 cycles. Each ack is a 1-cycle pulse.
- dma_lock=1, MAX_BURST=4, both requesting continuously → exactly 4 DMA grants with idle gap slots between them, then 1 CPU grant, then round-robin resumes.
- rst_n=0 in the cycle of a CPU write to 0x500 (prior value 0x1111) → M[0x500] stays 0x1111. All outputs are 0 on the next cycle.
- No requests for 10 cycles → mem_write_enable=0, mem_address=0, last_owner=00 throughout.
